// File: rtl/msg_rx_q_if.sv
// Byte-stream input and queue-head output bundle of the message receiver.
// Vectors are descending ([7:0]); bit 7 is the byte MSB, matching the numeric values on the wire.
interface msg_rx_q_if #(
    parameter int DATA_BYTES = 2
) ();
    logic [7:0]              uart_data;
    logic                    uart_ready;
    logic                    pop;
    logic                    valid;
    logic [7:0]              cmd;
    logic [7:0]              a1;
    logic [8*DATA_BYTES-1:0] a2;
    logic [8*DATA_BYTES-1:0] a3;

    modport slave (
        input  uart_data, uart_ready, pop,
        output valid, cmd, a1, a2, a3
    );

    modport master (
        output uart_data, uart_ready, pop,
        input  valid, cmd, a1, a2, a3
    );
endinterface

// File: rtl/msg_rx_q.sv
// Deframes UART bytes into command messages (cmd + optional a1/a2/a3) and queues
// complete messages in a DEPTH-entry first-word-fall-through FIFO.
module msg_rx_q #(
    parameter int DEPTH      = 2,
    parameter int DATA_BYTES = 2,
    parameter int TIMEOUT    = 50000
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    msg_rx_q_if.slave              bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   cmd_seen,
    output logic                   timeout_p,
    output logic                   overflow_p,
    output logic [7:0]             drop_count
);
    localparam int AW = 8 * DATA_BYTES;
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARG1, ARG2, ARG3} state_t;

    typedef struct packed {
        logic [7:0]    cmd;
        logic [7:0]    a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
    } entry_t;

    state_t        state_q, state_d;
    logic [1:0]    bc_q, bc_d;
    logic [TW-1:0] timer_q, timer_d;
    entry_t        stg_q, stg_d;
    logic          commit, expire;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          cmd_seen_q, timeout_q, overflow_q;
    logic [7:0]    drop_q;
    logic          full, do_pop, do_wr, drop;

    // Presence flags: spec bits cmd[1..3] are byte bits 6..4 (bit 7 is request/response).
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        stg_d   = stg_q;
        timer_d = timer_q;
        commit  = 1'b0;
        expire  = 1'b0;
        if (bus.uart_ready) begin
            timer_d = '0;
            unique case (state_q)
                IDLE: begin
                    stg_d     = '0;
                    stg_d.cmd = bus.uart_data;
                    bc_d      = '0;
                    if (bus.uart_data[6])      state_d = ARG1;
                    else if (bus.uart_data[5]) state_d = ARG2;
                    else if (bus.uart_data[4]) state_d = ARG3;
                    else                       commit  = 1'b1;
                end
                ARG1: begin
                    stg_d.a1 = bus.uart_data;
                    if (stg_q.cmd[5])      state_d = ARG2;
                    else if (stg_q.cmd[4]) state_d = ARG3;
                    else begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
                ARG2, ARG3: begin
                    if (state_q == ARG2) stg_d.a2 = (stg_q.a2 << 8) | AW'(bus.uart_data);
                    else                 stg_d.a3 = (stg_q.a3 << 8) | AW'(bus.uart_data);
                    if (bc_q == 2'(DATA_BYTES - 1)) begin
                        bc_d = '0;
                        if (state_q == ARG2 && stg_q.cmd[4]) state_d = ARG3;
                        else begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        bc_d = bc_q + 2'd1;
                    end
                end
            endcase
        end else if (state_q != IDLE) begin
            if (timer_q == TW'(TIMEOUT - 1)) begin
                expire  = 1'b1;
                state_d = IDLE;
                bc_d    = '0;
                timer_d = '0;
                stg_d   = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // A commit into a full queue survives only if the head leaves on the same edge.
    assign full   = (count_q == (PW+1)'(DEPTH));
    assign do_pop = bus.pop && (count_q != '0);
    assign do_wr  = commit && !reset && (!full || do_pop);
    assign drop   = commit && !(!full || do_pop);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            bc_q       <= '0;
            timer_q    <= '0;
            stg_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            cmd_seen_q <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            timer_q    <= timer_d;
            stg_q      <= stg_d;
            cmd_seen_q <= bus.uart_ready && (state_q == IDLE);
            timeout_q  <= expire;
            overflow_q <= drop;
            if (do_wr)  wptr_q <= wptr_q + PW'(1);
            if (do_pop) rptr_q <= rptr_q + PW'(1);
            if (do_wr && !do_pop)      count_q <= count_q + (PW+1)'(1);
            else if (!do_wr && do_pop) count_q <= count_q - (PW+1)'(1);
            if ((expire || drop) && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_wr) mem_q[wptr_q] <= stg_d;
    end

    // Head fields are forced to zero while empty so reset leaves every output at 0.
    entry_t head;
    assign head       = mem_q[rptr_q];
    assign bus.valid  = (count_q != '0);
    assign bus.cmd    = bus.valid ? head.cmd : '0;
    assign bus.a1     = bus.valid ? head.a1  : '0;
    assign bus.a2     = bus.valid ? head.a2  : '0;
    assign bus.a3     = bus.valid ? head.a3  : '0;
    assign count      = count_q;
    assign busy       = (state_q != IDLE);
    assign cmd_seen   = cmd_seen_q;
    assign timeout_p  = timeout_q;
    assign overflow_p = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_msg_rx_q.sv
// Bench for msg_rx_q: a byte-buffer message model checked every cycle, plus
// hand-computed expectations at the points of interest of each scenario.
module tb_msg_rx_q;
    localparam int DEPTH = 2;
    localparam int DB    = 2;
    localparam int T     = 20;
    localparam int AW    = 8 * DB;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [1:0] count;
    logic       busy, cmd_seen, timeout_p, overflow_p;
    logic [7:0] drop_count;

    msg_rx_q_if #(.DATA_BYTES(DB)) bus ();

    msg_rx_q #(.DEPTH(DEPTH), .DATA_BYTES(DB), .TIMEOUT(T)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus.slave),
        .count     (count),
        .busy      (busy),
        .cmd_seen  (cmd_seen),
        .timeout_p (timeout_p),
        .overflow_p(overflow_p),
        .drop_count(drop_count)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Model: collect bytes of the message in progress; once the command byte's
    // flags say the message is complete, slice it into fields and queue it.
    typedef struct {
        logic [7:0]    cmd;
        logic [7:0]    a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] pb[$];
    int         idle, m_drop, k;
    bit         m_seen, m_tmo, m_ovf, popped, have;
    ent_t       e, h;

    function automatic int need(input logic [7:0] c);
        return 1 + int'(c[6]) + DB * int'(c[5]) + DB * int'(c[4]);
    endfunction

    always @(posedge clk_sys) begin
        if (reset) begin
            mq.delete();
            pb.delete();
            idle = 0; m_drop = 0;
            m_seen = 0; m_tmo = 0; m_ovf = 0;
        end else begin
            popped = bus.pop && (mq.size() > 0);
            have   = 0;
            m_seen = bus.uart_ready && (pb.size() == 0);
            m_tmo  = 0;
            m_ovf  = 0;
            if (bus.uart_ready) begin
                pb.push_back(bus.uart_data);
                idle = 0;
                if (pb.size() == need(pb[0])) begin
                    e.cmd = pb[0]; e.a1 = 0; e.a2 = 0; e.a3 = 0; k = 1;
                    if (pb[0][6]) begin e.a1 = pb[k]; k++; end
                    if (pb[0][5]) for (int i = 0; i < DB; i++) begin e.a2 = (e.a2 << 8) | AW'(pb[k]); k++; end
                    if (pb[0][4]) for (int i = 0; i < DB; i++) begin e.a3 = (e.a3 << 8) | AW'(pb[k]); k++; end
                    pb.delete();
                    if (mq.size() == DEPTH && !popped) begin
                        m_ovf = 1;
                        if (m_drop < 255) m_drop++;
                    end else have = 1;
                end
            end else if (pb.size() > 0) begin
                idle++;
                if (idle == T) begin
                    pb.delete();
                    idle  = 0;
                    m_tmo = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (popped) void'(mq.pop_front());
            if (have) mq.push_back(e);
        end
    end

    always @(negedge clk_sys) begin
        if (chk_on) begin
            h = '{default: 0};
            if (mq.size() > 0) h = mq[0];
            chk("valid",      32'(bus.valid),  32'(mq.size() != 0));
            chk("count",      32'(count),      32'(mq.size()));
            chk("cmd",        32'(bus.cmd),    32'(h.cmd));
            chk("a1",         32'(bus.a1),     32'(h.a1));
            chk("a2",         32'(bus.a2),     32'(h.a2));
            chk("a3",         32'(bus.a3),     32'(h.a3));
            chk("busy",       32'(busy),       32'(pb.size() != 0));
            chk("cmd_seen",   32'(cmd_seen),   32'(m_seen));
            chk("timeout_p",  32'(timeout_p),  32'(m_tmo));
            chk("overflow_p", 32'(overflow_p), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), 32'(m_drop));
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit p = 1'b0);
        bus.uart_data  = b;
        bus.uart_ready = 1'b1;
        bus.pop        = p;
        tick();
        bus.uart_ready = 1'b0;
        bus.pop        = 1'b0;
    endtask

    task automatic pop_one();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    logic [7:0] m1 [6] = '{8'hF3, 8'h05, 8'h12, 8'h34, 8'hAB, 8'hCD};

    initial begin
        bus.uart_data = '0; bus.uart_ready = 1'b0; bus.pop = 1'b0;
        tick(); tick();
        reset  = 1'b0;
        chk_on = 1'b1;
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drop",  32'(drop_count), 0);

        // full message, all arguments present
        foreach (m1[i]) send(m1[i]);
        chk("s1_valid", 32'(bus.valid), 1);
        chk("s1_cmd",   32'(bus.cmd), 32'hF3);
        chk("s1_a1",    32'(bus.a1),  32'h05);
        chk("s1_a2",    32'(bus.a2),  32'h1234);
        chk("s1_a3",    32'(bus.a3),  32'hABCD);
        chk("s1_count", 32'(count), 1);
        pop_one();
        chk("s1_pop_valid", 32'(bus.valid), 0);
        chk("s1_pop_count", 32'(count), 0);

        // zero-argument message
        send(8'h82);
        chk("s2_seen",  32'(cmd_seen), 1);
        chk("s2_valid", 32'(bus.valid), 1);
        chk("s2_cmd",   32'(bus.cmd), 32'h82);
        chk("s2_args",  32'(bus.a1) | 32'(bus.a2) | 32'(bus.a3), 0);
        chk("s2_busy",  32'(busy), 0);
        pop_one();

        // partial message times out, then sparse message completes
        send(8'hA3); send(8'h12);
        chk("s3_busy", 32'(busy), 1);
        repeat (T - 1) begin
            tick();
            chk("s3_early_tmo", 32'(timeout_p), 0);
        end
        tick();
        chk("s3_tmo",   32'(timeout_p), 1);
        chk("s3_busy0", 32'(busy), 0);
        chk("s3_drop",  32'(drop_count), 1);
        chk("s3_valid", 32'(bus.valid), 0);
        send(8'hA3); send(8'h12); send(8'h34);
        chk("s3_cmd", 32'(bus.cmd), 32'hA3);
        chk("s3_a1",  32'(bus.a1),  0);
        chk("s3_a2",  32'(bus.a2),  32'h1234);
        chk("s3_a3",  32'(bus.a3),  0);
        pop_one();

        // overflow on the third message
        reset = 1'b1; tick(); reset = 1'b0;
        send(8'h81); send(8'h82); send(8'h83);
        chk("s4_ovf",   32'(overflow_p), 1);
        chk("s4_count", 32'(count), 2);
        chk("s4_drop",  32'(drop_count), 1);
        chk("s4_head",  32'(bus.cmd), 32'h81);

        // commit while full with a same-cycle pop
        send(8'h84, 1'b1);
        chk("s5_ovf",   32'(overflow_p), 0);
        chk("s5_count", 32'(count), 2);
        chk("s5_head",  32'(bus.cmd), 32'h82);
        pop_one();
        chk("s5_head2", 32'(bus.cmd), 32'h84);
        pop_one();
        chk("s5_empty", 32'(bus.valid), 0);

        // byte arriving in the expiry cycle wins over the timeout
        send(8'hF3);
        repeat (T - 1) tick();
        send(8'h05);
        chk("s5_no_tmo", 32'(timeout_p), 0);
        chk("s5_busy",   32'(busy), 1);
        tick();
        chk("s5_no_tmo2", 32'(timeout_p), 0);

        // reset mid-message, with a byte strobed during reset
        reset = 1'b1; bus.uart_data = 8'h81; bus.uart_ready = 1'b1;
        tick();
        reset = 1'b0; bus.uart_ready = 1'b0;
        chk("s6_rst_valid", 32'(bus.valid), 0);
        send(8'h82);
        chk("s6_valid", 32'(bus.valid), 1);
        chk("s6_cmd",   32'(bus.cmd), 32'h82);
        chk("s6_drop",  32'(drop_count), 0);
        chk("s6_tmo",   32'(timeout_p), 0);
        repeat (T + 2) tick();
        pop_one();

        // drop counter saturates
        repeat (300) begin
            send(8'h40);
            repeat (T) tick();
        end
        chk("s6_sat",  32'(drop_count), 255);
        chk("s6_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
